// File: rtl/exp4_pkg.sv
// Shared definitions for the sequence-checking game controller: state codes,
// decoded control outputs and the default timeout length.
package exp4_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 5000;

    // Codes are shown on the hex display, so they are fixed rather than auto-numbered.
    typedef enum logic [3:0] {
        ST_INICIAL     = 4'h0,
        ST_PREPARACAO  = 4'h1,
        ST_ESPERA      = 4'h2,
        ST_REGISTRA    = 4'h4,
        ST_COMPARACAO  = 4'h5,
        ST_PROXIMO     = 4'h6,
        ST_FIM_ACERTOU = 4'hA,
        ST_FIM_TIMEOUT = 4'hD,
        ST_FIM_ERROU   = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
    } ctrl_t;

    function automatic ctrl_t decode_saidas(input estado_t estado);
        ctrl_t s;
        s = '0;
        case (estado)
            ST_PREPARACAO: begin
                s.zera_c = 1'b1;
                s.zera_r = 1'b1;
            end
            ST_REGISTRA:    s.registra_r = 1'b1;
            ST_PROXIMO:     s.conta_c    = 1'b1;
            ST_FIM_ACERTOU: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            ST_FIM_ERROU: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            ST_FIM_TIMEOUT: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
`endif
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Registered rising-edge detector: one-cycle pulso per low-to-high sinal transition,
// one cycle after the edge is sampled. A held input yields a single pulse.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;
    logic pulso_q;
    logic pulso_d;

    assign pulso_d = sinal & ~sinal_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal_q <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            sinal_q <= sinal;
            pulso_q <= pulso_d;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/exp4_unidade_controle.sv
// Moore controller for the sequence game: registered state and outputs, jogada press to registraR in 2 cycles.
// Define TIMEOUT_EN to add the fim_timeout state after TIMEOUT_CYCLES idle cycles in espera_jogada.
module exp4_unidade_controle
    import exp4_pkg::*;
`ifdef TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    ctrl_t   saida_q;
    logic    jogada_pulse;

`ifdef TIMEOUT_EN
    logic [31:0] tempo_q;
    logic        tempo_esgotado;

    assign tempo_esgotado = (tempo_q == 32'(TIMEOUT_CYCLES - 1));
`endif

    edge_detector u_jogada_edge (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jogada_pulse)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_INICIAL:    if (iniciar) estado_d = ST_PREPARACAO;
            ST_PREPARACAO: estado_d = ST_ESPERA;
            ST_ESPERA: begin
                if (jogada_pulse) begin
                    estado_d = ST_REGISTRA;
                end
`ifdef TIMEOUT_EN
                else if (tempo_esgotado) begin
                    estado_d = ST_FIM_TIMEOUT;
                end
`endif
            end
            ST_REGISTRA:   estado_d = ST_COMPARACAO;
            // A mismatch wins over fimC, so a wrong last entry still fails.
            ST_COMPARACAO: begin
                if (!igual)     estado_d = ST_FIM_ERROU;
                else if (fimC)  estado_d = ST_FIM_ACERTOU;
                else            estado_d = ST_PROXIMO;
            end
            ST_PROXIMO:    estado_d = ST_ESPERA;
            ST_FIM_ACERTOU,
            ST_FIM_ERROU:  if (iniciar) estado_d = ST_PREPARACAO;
`ifdef TIMEOUT_EN
            ST_FIM_TIMEOUT: if (iniciar) estado_d = ST_PREPARACAO;
`endif
            default:       estado_d = ST_INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with estado_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
            saida_q  <= '0;
`ifdef TIMEOUT_EN
            tempo_q  <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            saida_q  <= decode_saidas(estado_d);
`ifdef TIMEOUT_EN
            if (estado_q == ST_ESPERA && estado_d == ST_ESPERA) begin
                tempo_q <= tempo_q + 32'd1;
            end else begin
                tempo_q <= '0;
            end
`endif
        end
    end

    assign zeraC     = saida_q.zera_c;
    assign contaC    = saida_q.conta_c;
    assign zeraR     = saida_q.zera_r;
    assign registraR = saida_q.registra_r;
    assign pronto    = saida_q.pronto;
    assign acertou   = saida_q.acertou;
    assign errou     = saida_q.errou;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed self-checking bench for exp4_unidade_controle; timeout scenario runs only with TIMEOUT_EN.
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       fimC = 1'b0;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
    logic [3:0] db_estado;
    logic [6:0] outs;

    int total = 0;
    int bad = 0;
    int n_reg = 0;
    int n_conta = 0;

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_PREP = 7'b1010000;
    localparam logic [6:0] O_REG  = 7'b0001000;
    localparam logic [6:0] O_PROX = 7'b0100000;
    localparam logic [6:0] O_OK   = 7'b0000110;
    localparam logic [6:0] O_ERR  = 7'b0000101;

`ifdef TIMEOUT_EN
    exp4_unidade_controle #(.TIMEOUT_CYCLES(8)) dut (
`else
    exp4_unidade_controle dut (
`endif
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .db_estado (db_estado)
    );

    assign outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou};

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (registraR) n_reg++;
        if (contaC) n_conta++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++;
        if ({db_estado, outs} !== {4'h0, O_NONE}) begin
            bad++;
            $display("FAIL reset_state got=%h/%b want=0/%b", db_estado, outs, O_NONE);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            jogada = ~jogada;
            tick();
        end
        jogada = 1'b0;
        tick(2);
        total++;
        if ({db_estado, outs} !== {4'h0, O_NONE}) begin
            bad++;
            $display("FAIL idle_hold got=%h/%b want=0/%b", db_estado, outs, O_NONE);
        end
    endtask

    task automatic test_success();
        int c0;
        iniciar = 1'b1;
        tick();
        total++;
        if ({db_estado, outs} !== {4'h1, O_PREP}) begin
            bad++;
            $display("FAIL success_prep got=%h/%b want=1/%b", db_estado, outs, O_PREP);
        end
        iniciar = 1'b0;
        tick();
        total++;
        if ({db_estado, outs} !== {4'h2, O_NONE}) begin
            bad++;
            $display("FAIL success_espera got=%h/%b want=2/%b", db_estado, outs, O_NONE);
        end
        c0 = n_conta;
        for (int a = 0; a < 4; a++) begin
            igual = 1'b1;
            fimC = (a == 3);
            jogada = 1'b1;
            tick();
            total++;
            if (db_estado !== 4'h2) begin
                bad++;
                $display("FAIL success_latency1 addr=%0d got=%h want=2", a, db_estado);
            end
            tick();
            total++;
            if ({db_estado, outs} !== {4'h4, O_REG}) begin
                bad++;
                $display("FAIL success_registra addr=%0d got=%h/%b want=4/%b", a, db_estado, outs, O_REG);
            end
            jogada = 1'b0;
            tick();
            total++;
            if ({db_estado, outs} !== {4'h5, O_NONE}) begin
                bad++;
                $display("FAIL success_compara addr=%0d got=%h/%b want=5/%b", a, db_estado, outs, O_NONE);
            end
            tick();
            if (a < 3) begin
                total++;
                if ({db_estado, outs} !== {4'h6, O_PROX}) begin
                    bad++;
                    $display("FAIL success_proximo addr=%0d got=%h/%b want=6/%b", a, db_estado, outs, O_PROX);
                end
                tick();
            end
        end
        tick(3);
        total++;
        if ({db_estado, outs} !== {4'hA, O_OK}) begin
            bad++;
            $display("FAIL success_fim got=%h/%b want=a/%b", db_estado, outs, O_OK);
        end
        total++;
        if (n_conta - c0 !== 3) begin
            bad++;
            $display("FAIL success_conta_pulses got=%0d want=3", n_conta - c0);
        end
        fimC = 1'b0;
    endtask

    task automatic test_mismatch();
        int c0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        c0 = n_conta;
        for (int a = 0; a < 3; a++) begin
            igual = (a != 2);
            fimC = 1'b0;
            jogada = 1'b1;
            tick(2);
            jogada = 1'b0;
            tick(2);
            if (a < 2) tick();
        end
        tick(2);
        total++;
        if ({db_estado, outs} !== {4'hE, O_ERR}) begin
            bad++;
            $display("FAIL mismatch_fim got=%h/%b want=e/%b", db_estado, outs, O_ERR);
        end
        total++;
        if (n_conta - c0 !== 2) begin
            bad++;
            $display("FAIL mismatch_conta_pulses got=%0d want=2", n_conta - c0);
        end
        iniciar = 1'b1;
        tick();
        total++;
        if ({db_estado, outs} !== {4'h1, O_PREP}) begin
            bad++;
            $display("FAIL mismatch_restart got=%h/%b want=1/%b", db_estado, outs, O_PREP);
        end
        iniciar = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        igual = 1'b0;
        fimC = 1'b1;
        jogada = 1'b1;
        tick(2);
        jogada = 1'b0;
        tick(2);
        total++;
        if ({db_estado, outs} !== {4'hE, O_ERR}) begin
            bad++;
            $display("FAIL priority_last_mismatch got=%h/%b want=e/%b", db_estado, outs, O_ERR);
        end
        fimC = 1'b0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
    endtask

    task automatic test_held_button();
        int r0;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        total++;
        if (db_estado !== 4'h2) begin
            bad++;
            $display("FAIL held_iniciar_ignored got=%h want=2", db_estado);
        end
        igual = 1'b1;
        fimC = 1'b0;
        r0 = n_reg;
        jogada = 1'b1;
        tick(20);
        total++;
        if (db_estado !== 4'h2) begin
            bad++;
            $display("FAIL held_state got=%h want=2", db_estado);
        end
        total++;
        if (n_reg - r0 !== 1) begin
            bad++;
            $display("FAIL held_registra_pulses got=%0d want=1", n_reg - r0);
        end
        jogada = 1'b0;
        tick(2);
        r0 = n_reg;
        jogada = 1'b1;
        tick(2);
        jogada = 1'b0;
        tick();
        total++;
        if (db_estado !== 4'h5) begin
            bad++;
            $display("FAIL late_press_compara got=%h want=5", db_estado);
        end
        jogada = 1'b1;
        tick(2);
        jogada = 1'b0;
        tick(4);
        total++;
        if (db_estado !== 4'h2) begin
            bad++;
            $display("FAIL late_press_lost got=%h want=2", db_estado);
        end
        total++;
        if (n_reg - r0 !== 1) begin
            bad++;
            $display("FAIL late_press_pulses got=%0d want=1", n_reg - r0);
        end
    endtask

    task automatic test_async_reset();
        igual = 1'b1;
        fimC = 1'b0;
        jogada = 1'b1;
        tick(2);
        jogada = 1'b0;
        tick(2);
        total++;
        if ({db_estado, outs} !== {4'h6, O_PROX}) begin
            bad++;
            $display("FAIL areset_pre got=%h/%b want=6/%b", db_estado, outs, O_PROX);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({db_estado, outs} !== {4'h0, O_NONE}) begin
            bad++;
            $display("FAIL areset_immediate got=%h/%b want=0/%b", db_estado, outs, O_NONE);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (db_estado !== 4'h0) begin
            bad++;
            $display("FAIL areset_after got=%h want=0", db_estado);
        end
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick(7);
        total++;
        if (db_estado !== 4'h2) begin
            bad++;
            $display("FAIL timeout_early got=%h want=2", db_estado);
        end
        tick();
        total++;
        if ({db_estado, outs} !== {4'hD, O_ERR}) begin
            bad++;
            $display("FAIL timeout_fim got=%h/%b want=d/%b", db_estado, outs, O_ERR);
        end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick(6);
        jogada = 1'b1;
        tick();
        total++;
        if (db_estado !== 4'h2) begin
            bad++;
            $display("FAIL timeout_pulse_wait got=%h want=2", db_estado);
        end
        tick();
        total++;
        if (db_estado !== 4'h4) begin
            bad++;
            $display("FAIL timeout_pulse_wins got=%h want=4", db_estado);
        end
        jogada = 1'b0;
        tick(2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_success();
        test_mismatch();
        test_priority();
        test_held_button();
        test_async_reset();
`ifdef TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exp4_unidade_controle.md
Name: exp4_unidade_controle

Overview:
Moore control unit that sequences the counter/register/memory/comparator datapath as a sequence-checking game. After iniciar, each jogada press latches the switches, compares them to the memory word at the current address, and advances the address. Ends in success after the last address matches, or in failure on the first mismatch. Sits between the top-level inputs and the datapath, replacing the single-pass sequencing of the previous experiment.

Parameters:
TIMEOUT_CYCLES, 5000, cycles without a jogada pulse in espera_jogada before timeout (used only with TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces state inicial
iniciar  input  1  start request, level-sampled
jogada  input  1  player confirm button, level; internally edge-detected
igual  input  1  datapath comparator: registered switches equal memory word
fimC  input  1  datapath counter at terminal address
zeraC  output  1  clear address counter
contaC  output  1  increment address counter
zeraR  output  1  clear switch register
registraR  output  1  load switch register
pronto  output  1  game finished
acertou  output  1  finished with all matches
errou  output  1  finished with mismatch (or timeout)
db_estado  output  4  current state code for hex display

Behaviour:
- Registered state, outputs decoded from current state only (Moore); no output depends combinationally on inputs.
- Reset (async, any time, including mid-game): state inicial (0x0); all control outputs 0; edge-detector history flop 0; timeout counter 0.
- Edge detect: jogada_pulse = jogada & ~jogada_q; jogada_q is a flop of jogada. A held button produces exactly one pulse.
- State codes / outputs:
  inicial 0x0: all 0.
  preparacao 0x1: zeraC=1, zeraR=1.
  espera_jogada 0x2: all 0.
  registra 0x4: registraR=1.
  comparacao 0x5: all 0.
  proximo 0x6: contaC=1.
  fim_acertou 0xA: pronto=1, acertou=1.
  fim_errou 0xE: pronto=1, errou=1.
  fim_timeout 0xD (TIMEOUT_EN only): pronto=1, errou=1.
  Any unused code: all 0; next state inicial.
- Transitions:
  inicial: iniciar -> preparacao, else hold.
  preparacao -> espera_jogada (unconditional, one cycle).
  espera_jogada: jogada_pulse -> registra, else hold.
  registra -> comparacao (one cycle; register value valid in comparacao).
  comparacao: !igual -> fim_errou; igual & fimC -> fim_acertou; igual & !fimC -> proximo.
  proximo -> espera_jogada.
  fim_*: iniciar -> preparacao, else hold (outputs stay asserted).
- igual has priority over fimC: a mismatch at the last address is fim_errou.
- iniciar is ignored in all states except inicial and fim_*.
- jogada_pulse is ignored outside espera_jogada. A pulse arriving during registra/comparacao/proximo is lost; the player must release and press again.
- Latency: jogada rising edge to registraR = 2 cycles (1 for the edge flop, 1 for the state register).

Optional Feature:
TIMEOUT_EN
- Defined: a counter clears on entry to espera_jogada and increments each cycle spent there. When it reaches TIMEOUT_CYCLES-1 with no jogada_pulse, next state is fim_timeout.
- If a jogada_pulse arrives in the same cycle as the limit, the pulse wins (-> registra).
- The counter is held at 0 outside espera_jogada.
- Not defined: no counter, no fim_timeout state, and code 0xD is treated as unused.

Decomposition:
- Shared package exp4_pkg: 4-bit state localparams (values above) and the default TIMEOUT_CYCLES.
- One sub-module: edge_detector (clock, reset, sinal, pulso), reused later for other buttons.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> db_estado=0x0, all outputs 0. Toggling jogada with iniciar=0 keeps db_estado=0x0.
- Full success, 4 addresses with igual=1 at every compare: iniciar -> zeraC=zeraR=1 for exactly 1 cycle. Each jogada press -> registraR for 1 cycle, then contaC for 1 cycle. After the 4th press with fimC=1 -> db_estado=0xA, pronto=1, acertou=1, held.
- Mismatch at address 2: igual=0 in comparacao -> db_estado=0xE, pronto=1, errou=1, contaC never pulses a 3rd time. Then iniciar -> preparacao (0x1) with zeraC=1.
- Held button: jogada high for 20 cycles in espera_jogada -> exactly one registraR pulse. Second press while in comparacao -> no effect.
- Async reset mid-game in proximo (between clock edges) -> db_estado=0x0 and contaC=0 immediately, before the next edge.
- TIMEOUT_EN, TIMEOUT_CYCLES=8: no jogada for 8 cycles in espera_jogada -> db_estado=0xD, errou=1. A pulse on the 8th cycle -> registra instead.
